// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 4-digit display, with a minimum time slice per owner.
// Optional DISPLAY_ARB_BLANK_IDLE_EN: when defined, bcd_out is cleared on release and reads 0 while idle.
//
// state | meaning
// IDLE  | no grant; the next request wins, searching from the pointer plus one
// HOLD  | one requester owns the display; bcd_out tracks its live data word
module display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 100000000,
  parameter int DATA_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy,
  output logic [DATA_W-1:0]             bcd_out
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [DATA_W-1:0]    bcd_q, bcd_d;

  logic [DATA_W-1:0]    words [NUM_REQ];
  logic [OW-1:0]        win;
  logic [NUM_REQ-1:0]   others;

  // First set bit strictly after p, wrapping; p itself is reached last.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [OW-1:0] p);
    logic [OW-1:0] w;
    int idx;
    w = p;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (r[OW'(idx)]) w = OW'(idx);
    end
    return w;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) words[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign win    = rr_pick(req, ptr_q);
  assign others = req & ~grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d      = HOLD;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          ptr_d        = win;
          busy_d       = 1'b1;
          cnt_d        = '0;
          bcd_d        = words[win];
        end
      end
      HOLD: begin
        // Release takes priority over an expired slice.
        if (!req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
`ifdef DISPLAY_ARB_BLANK_IDLE_EN
          bcd_d   = '0;
`else
          bcd_d   = bcd_q;
`endif
        end else if (cnt_q == CNT_MAX && |others) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          owner_d      = win;
          ptr_d        = win;
          cnt_d        = '0;
          bcd_d        = words[win];
        end else begin
          bcd_d = words[owner_q];
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(NUM_REQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      bcd_q   <= bcd_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter (4 requesters, 8-cycle slices) with a slice-age reference model.
module tb_display_arbiter;

  localparam int NR = 4;
  localparam int HC = 8;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = 4'b1111;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     grant;
  logic [1:0]        owner;
  logic              busy;
  logic [DW-1:0]     bcd_out;

  int errors = 0;
  int checks = 0;

  display_arbiter #(.NUM_REQ(NR), .HOLD_CYCLES(HC), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .grant(grant), .owner(owner), .busy(busy), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the display and for how long, tracked as an unbounded age.
  bit            m_busy  = 1'b0;
  int            m_owner = 0;
  int            m_last  = NR - 1;
  int            m_age   = 0;
  logic [DW-1:0] m_bcd   = '0;

  function automatic int next_after(input logic [NR-1:0] r, input int from);
    int idx;
    for (int k = 1; k <= NR; k++) begin
      idx = (from + k) % NR;
      if (r[idx[1:0]]) return idx;
    end
    return from;
  endfunction

  function automatic logic [DW-1:0] word_of(input int i);
    return req_data[i*DW +: DW];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 0; m_last = NR - 1; m_age = 0; m_bcd = '0;
    end else if (!m_busy) begin
      if (req != '0) begin
        m_owner = next_after(req, m_last);
        m_last  = m_owner;
        m_busy  = 1'b1;
        m_age   = 0;
        m_bcd   = word_of(m_owner);
      end
    end else if (((req >> m_owner) & 4'b0001) == 4'b0000) begin
      m_busy = 1'b0;
`ifdef DISPLAY_ARB_BLANK_IDLE_EN
      m_bcd  = '0;
`endif
    end else if (m_age >= HC - 1 && (req & ~(4'b0001 << m_owner)) != '0) begin
      m_owner = next_after(req, m_owner);
      m_last  = m_owner;
      m_age   = 0;
      m_bcd   = word_of(m_owner);
    end else begin
      m_age++;
      m_bcd = word_of(m_owner);
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("model_grant", 32'(grant), 32'(m_busy ? (4'b0001 << m_owner) : 4'b0000));
      chk("model_owner", 32'(owner), 32'(m_owner));
      chk("model_busy", 32'(busy), 32'(m_busy));
      chk("model_bcd", 32'(bcd_out), 32'(m_bcd));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    req_data = {16'h0303, 16'h1234, 16'h0202, 16'h0101};

    tick(3);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_bcd", 32'(bcd_out), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);

    rst_n = 1'b1;
    req = 4'b0100;
    tick(1);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_owner", 32'(owner), 32'h2);
    chk("single_bcd", 32'(bcd_out), 32'h1234);
    req_data[2*DW +: DW] = 16'h5678;
    tick(1);
    chk("single_track", 32'(bcd_out), 32'h5678);

    req = 4'b0000;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    req = 4'b1111;
    for (int c = 0; c <= 32; c++) begin
      tick(1);
      chk("rr_seq", 32'(grant), 32'(4'b0001 << ((c / HC) % NR)));
    end

    tick(8);
    chk("rr_owner1", 32'(grant), 32'h2);
    tick(2);
    req = 4'b1001;
    tick(1);
    chk("release_grant", 32'(grant), 32'h0);
    chk("release_busy", 32'(busy), 32'h0);
`ifdef DISPLAY_ARB_BLANK_IDLE_EN
    chk("release_bcd", 32'(bcd_out), 32'h0);
`else
    chk("release_bcd", 32'(bcd_out), 32'h0202);
`endif
    chk("release_owner", 32'(owner), 32'h1);
    tick(1);
    chk("after_idle_grant", 32'(grant), 32'h8);
    chk("after_idle_bcd", 32'(bcd_out), 32'h0303);

    req = 4'b0001;
    tick(22);
    chk("sat_grant", 32'(grant), 32'h1);
    req = 4'b0101;
    tick(1);
    chk("sat_preempt", 32'(grant), 32'h4);
    chk("sat_bcd", 32'(bcd_out), 32'h5678);

    tick(2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_bcd", 32'(bcd_out), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    tick(1);
    rst_n = 1'b1;
    req = 4'b1111;
    tick(1);
    chk("post_rst_first", 32'(grant), 32'h1);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
